router_fifo: RTL
================

Name: router_fifo

Overview:
- One of three identical output buffers, directly downstream of the router synchronizer.
- Accepts bytes when its one-hot write-enable bit is set, and returns `full`/`empty` to the synchronizer.
- Presents bytes to the output port on `read_enb`.
- Tags each header byte so it can track packet length on read-out, blanking `data_out` between packets.
- Flushes on the synchronizer's `soft_reset` time-out.

Parameters:
- WIDTH, 8, payload byte width.
- DEPTH, 16, storage entries. Must be a power of 2.
- AW, 4, pointer width, log2(DEPTH).

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- soft_reset  in  1  synchronous flush from the synchronizer time-out.
- write_enb  in  1  write strobe (one bit of the synchronizer's write_enb vector).
- read_enb  in  1  read strobe from the output port.
- lfd_state  in  1  high when the byte being written is a packet header.
- data_in  in  WIDTH  byte to store.
- data_out  out  WIDTH  registered read data; 0 when no packet is in progress.
- full  out  1  all DEPTH entries occupied.
- empty  out  1  no entries occupied.

Behaviour:
- Storage: DEPTH x (WIDTH+1). Bit WIDTH holds `lfd_state` captured with the byte.
- Pointers: `wr_ptr` and `rd_ptr` are AW+1 bits; the extra bit distinguishes full from empty.
  - `empty` = pointers equal.
  - `full` = low AW bits equal and MSBs differ.
  - Both are combinational from the pointers.
- Write accepted when `write_enb && !full`:
  - entry[wr_ptr] <= {lfd_state, data_in}; wr_ptr increments and wraps modulo 2*DEPTH.
  - A write while full is dropped; no pointer change, no error flag.
- Read accepted when `read_enb && !empty`:
  - data_out <= entry[rd_ptr][WIDTH-1:0] on the same edge; rd_ptr increments.
  - Read latency is one cycle: the byte is visible on the cycle after `read_enb` is sampled.
- Read while empty: no pointer change.
  - data_out holds if `pkt_cnt` != 0.
  - data_out <= 0 if `pkt_cnt` == 0.
- Simultaneous read and write:
  - Both are accepted independently under the rules above.
  - When full, only the read is accepted; the write is dropped because `full` is evaluated before the edge.
  - When empty, only the write is accepted; there is no fall-through.
- Packet counter `pkt_cnt` (7 bits):
  - On an accepted read of a header-tagged entry: pkt_cnt <= data[7:2] + 1. This counts payload bytes plus the parity byte; the header itself is not counted.
  - On an accepted read of a non-header entry with pkt_cnt != 0: pkt_cnt decrements.
  - When pkt_cnt == 0 and no header is being read, data_out <= 0 on the next edge. This blanks the output between packets.
- reset: wr_ptr, rd_ptr, pkt_cnt, and data_out all clear to 0. Outputs after reset: empty=1, full=0, data_out=0.
  - Storage contents are not cleared, and reads of them are not defined.
- soft_reset:
  - Same effect as reset on pointers, pkt_cnt and data_out.
  - Takes priority over a same-cycle read or write; both are discarded.
  - Usable mid-packet: the partial packet is lost and the next write starts cleanly at entry 0.
- Priority: reset > soft_reset > read/write.
- Header length 0 (data[7:2]=0): pkt_cnt loads 1, so exactly one further byte (parity) is delivered before blanking.

Decomposition:
- Shared router package holds:
  - WIDTH
  - the header field positions: length = [7:2], address = [1:0]
  - the packet-counter width constant (7)
- One natural sub-module: `router_fifo_mem`, a plain synchronous-write DEPTH x (WIDTH+1) array with combinational read address.
- Pointers, flags and pkt_cnt stay in the top.

Test Plan:
- Reset: assert reset 2 cycles.
  -> empty=1, full=0, data_out=0.
- Single packet: write header 0x0D (length 3, address 1) with lfd_state=1, then 0x11, 0x22, 0x33, parity 0x5A; then read 5 times.
  -> data_out sequence 0x0D, 0x11, 0x22, 0x33, 0x5A, each one cycle after its read; empty=1 afterwards.
  -> On a sixth read, data_out=0 on the next cycle.
- Fill and overflow: write 16 bytes 0x00..0x0F, with header 0x3C first.
  -> full=1 after the 16th write.
  -> A 17th write of 0xFF is dropped.
  -> 16 reads return 0x3C, 0x01..0x0F, with no 0xFF.
- Wrap-around: write 10, read 10, write 10, read 10.
  -> Data is intact in order across the pointer wrap; empty=1 at the end.
- Simultaneous read/write:
  - At occupancy 5: one cycle with both strobes -> occupancy stays 5, order preserved.
  - When full: both strobes -> one read, write dropped, full deasserts.
- Soft reset mid-packet: write header 0x0C plus 2 bytes, read 2, then pulse soft_reset while a write is asserted.
  -> empty=1, data_out=0, the concurrent write is discarded.
  -> The next packet reads back correctly from entry 0.

Source files
------------

// File: rtl/router_fifo_pkg.sv
// Shared router constants: byte width, header field layout, packet-counter width.
// No logic; pure declarations plus header field extraction helpers.
// Imported by every router block that interprets header bytes.
package router_fifo_pkg;

  localparam int BYTE_WIDTH = 8;

  // Header byte layout: length in the upper six bits, destination port in the lower two.
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_LEN_W    = HDR_LEN_MSB - HDR_LEN_LSB + 1;
  localparam int HDR_ADDR_W   = HDR_ADDR_MSB - HDR_ADDR_LSB + 1;

  // Wide enough for the largest length (63) plus the parity byte.
  localparam int PKT_CNT_W = 7;

  function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [BYTE_WIDTH-1:0] b);
    return b[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

  function automatic logic [HDR_ADDR_W-1:0] hdr_addr(input logic [BYTE_WIDTH-1:0] b);
    return b[HDR_ADDR_MSB:HDR_ADDR_LSB];
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for the router output FIFO: DEPTH entries of WIDTH+1 bits.
// Write takes effect on the rising edge; read is combinational from rd_addr.
// No flow control here; the owner guarantees writes only into free entries.
module router_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH:0]   wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH:0]   rd_data
);

  logic [WIDTH:0] mem [DEPTH];

  // Contents are deliberately never cleared; pointers decide what is valid.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_fifo.sv
// Router output buffer: stores header-tagged bytes, tracks packet length on read-out.
// Read data appears one cycle after read_enb; no fall-through when empty.
// Writes while full are silently dropped; full/empty go back to the synchronizer.
module router_fifo
  import router_fifo_pkg::*;
#(
  parameter int WIDTH = BYTE_WIDTH,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int PW = AW + 1;

  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PKT_CNT_W-1:0] pkt_cnt;
  logic [WIDTH:0]       rd_entry;
  logic                 wr_ok;
  logic                 rd_ok;
  logic                 rd_hdr;

  // Extra pointer MSB separates the "wrapped once" full case from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign wr_ok  = write_enb && !full;
  assign rd_ok  = read_enb && !empty;
  assign rd_hdr = rd_entry[WIDTH];

  router_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock   (clock),
    .wr_en   (wr_ok && !reset && !soft_reset),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({lfd_state, data_in}),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_entry)
  );

  // Pointer update; a flush discards any same-cycle read or write.
  always_ff @(posedge clock) begin
    if (reset || soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Remaining bytes in the packet being read: header reload counts payload plus parity.
  always_ff @(posedge clock) begin
    if (reset || soft_reset) begin
      pkt_cnt <= '0;
    end else if (rd_ok) begin
      if (rd_hdr) begin
        pkt_cnt <= PKT_CNT_W'(hdr_len(rd_entry[WIDTH-1:0])) + PKT_CNT_W'(1);
      end else if (pkt_cnt != '0) begin
        pkt_cnt <= pkt_cnt - PKT_CNT_W'(1);
      end
    end
  end

  // Registered read data; blanked to zero between packets when nothing is read.
  always_ff @(posedge clock) begin
    if (reset || soft_reset) begin
      data_out <= '0;
    end else if (rd_ok) begin
      data_out <= rd_entry[WIDTH-1:0];
    end else if (pkt_cnt == '0) begin
      data_out <= '0;
    end
  end

endmodule
